// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: load/store front end for the single-port Memory block.
// A request is accepted in IDLE and checked for alignment and range. A good
// request holds CS/WE/ADDR for WAIT_CYCLES+1 cycles. A bad request skips
// memory entirely. The response is then held until the consumer takes it.
// Every output is a flop. Mem_Bus is driven only while a store is in flight.
module mem_bus_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              ClK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              CS,
   output logic              WE,
   output logic [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] Mem_Bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              req_ready_d, rsp_valid_d, rsp_err_d, cs_d, we_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic [ADDR_W-1:0] addr_d;

   logic [ADDR_W-1:0] word_addr;
   logic              bad_req;

   // Word index and the alignment/range check on the incoming request
   always_comb begin
      word_addr = {2'b00, req_addr[ADDR_W-1:2]};
      bad_req   = (req_addr[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH));
   end

   // Store data goes onto the bus only while a write is selected
   assign Mem_Bus = (CS && WE) ? wdata_q : {DATA_W{1'bz}};

   // Next-state and next-output logic; all results land in flops below
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wdata_d     = wdata_q;
      req_ready_d = req_ready;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      cs_d        = CS;
      we_d        = WE;
      addr_d      = ADDR;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_ready_d = 1'b0;
               wdata_d     = req_wdata;
               if (bad_req) begin
                  // No memory cycle: answer straight away with an error
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  state_d = ACCESS;
                  cs_d    = 1'b1;
                  we_d    = req_we;
                  addr_d  = word_addr;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Memory has acted on the negedge; load data is on the bus now
               state_d     = RESP;
               cs_d        = 1'b0;
               we_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = WE ? '0 : Mem_Bus;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, synchronous reset
   always_ff @(posedge ClK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wdata_q   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         CS        <= 1'b0;
         WE        <= 1'b0;
         ADDR      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wdata_q   <= wdata_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         CS        <= cs_d;
         WE        <= we_d;
         ADDR      <= addr_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: instance 0 has WAIT_CYCLES=0 and instance 1 has
// WAIT_CYCLES=2. Each instance has a negedge memory model. Expected
// responses are queued when a request is driven. They are checked when
// rsp_valid shows up.
module tb_mem_bus_ctrl;

   logic        ClK = 1'b0;
   logic        RST = 1'b1;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic        rsp_err   [2];
   logic        cs        [2];
   logic        we        [2];
   logic [31:0] rsp_rdata [2];
   logic [31:0] addr_o    [2];
   logic [31:0] bus_obs   [2];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          csn;
   } exp_t;
   exp_t        sb[$];
   logic [31:0] exp_mem [2][128];

   int checks = 0;
   int errors = 0;

   // monitor state, written by the negedge monitor
   int          cs_cnt     [2];
   logic [31:0] first_addr [2];
   logic        addr_bad   [2];
   logic        we_seen    [2];
   logic [31:0] bus_seen   [2];

   always #5 ClK = ~ClK;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wire  [31:0] mbus;
      logic [31:0] mem [128];
      logic [31:0] mdrv;

      initial begin
         for (int i = 0; i < 128; i++) mem[i] = '0;
         mdrv = '0;
      end

      // memory model: acts on negedge, drives bus only for a selected read
      always @(negedge ClK) begin
         if (cs[g]) begin
            if (we[g]) mem[addr_o[g][6:0]] <= mbus;
            else       mdrv <= mem[addr_o[g][6:0]];
         end
      end
      assign mbus = (cs[g] && !we[g]) ? mdrv : 32'bz;
      assign bus_obs[g] = mbus;

      mem_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .WAIT_CYCLES(g*2)) dut (
         .ClK(ClK), .RST(RST),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready),
         .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
         .CS(cs[g]), .WE(we[g]), .ADDR(addr_o[g]), .Mem_Bus(mbus)
      );
   end

   // watch CS windows: length, ADDR stability, WE and store data on the bus
   always @(negedge ClK) begin
      for (int g = 0; g < 2; g++) begin
         if (cs[g]) begin
            if (cs_cnt[g] == 0) first_addr[g] = addr_o[g];
            else if (addr_o[g] != first_addr[g]) addr_bad[g] = 1'b1;
            cs_cnt[g]++;
            we_seen[g] = we[g];
            if (we[g]) bus_seen[g] = bus_obs[g];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // one request on instance g; optional stall cycles with rsp_ready low
   task automatic req(input int g, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int stall);
      exp_t        e;
      exp_t        got;
      int          n;
      logic [31:0] held;
      e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd128);
      e.rdata = (e.err || w) ? 32'd0 : exp_mem[g][a[8:2]];
      e.lat   = e.err ? 1 : 2 + 2*g;
      e.csn   = e.err ? 0 : 1 + 2*g;
      if (!e.err && w) exp_mem[g][a[8:2]] = d;
      @(negedge ClK);
      chk("req_ready_idle", {63'd0, req_ready[g]}, 64'd1);
      cs_cnt[g] = 0; addr_bad[g] = 1'b0; we_seen[g] = 1'b0; bus_seen[g] = '0;
      req_valid[g] = 1'b1; req_we = w; req_addr = a; req_wdata = d;
      sb.push_back(e);
      @(posedge ClK);
      n = 1;
      @(negedge ClK);
      req_valid[g] = 1'b0;
      while (!rsp_valid[g] && n < 50) begin
         @(posedge ClK); n++;
         @(negedge ClK);
      end
      got = sb.pop_front();
      chk("latency", 64'(n), 64'(got.lat));
      chk("rsp_rdata", {32'd0, rsp_rdata[g]}, {32'd0, got.rdata});
      chk("rsp_err", {63'd0, rsp_err[g]}, {63'd0, got.err});
      chk("cs_cycles", 64'(cs_cnt[g]), 64'(got.csn));
      if (!got.err) begin
         chk("addr_word", {32'd0, first_addr[g]}, {32'd0, a >> 2});
         chk("addr_stable", {63'd0, addr_bad[g]}, 64'd0);
         chk("we", {63'd0, we_seen[g]}, {63'd0, w});
         if (w) chk("bus_wdata", {32'd0, bus_seen[g]}, {32'd0, d});
      end
      if (stall > 0) begin
         held = rsp_rdata[g];
         req_valid[g] = 1'b1; req_we = 1'b0; req_addr = 32'h4;
         for (int i = 0; i < stall; i++) begin
            @(posedge ClK);
            @(negedge ClK);
            chk("stall_valid", {63'd0, rsp_valid[g]}, 64'd1);
            chk("stall_rdata", {32'd0, rsp_rdata[g]}, {32'd0, held});
            chk("stall_ready", {63'd0, req_ready[g]}, 64'd0);
            chk("stall_cs", {63'd0, cs[g]}, 64'd0);
         end
         req_valid[g] = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge ClK);
      @(negedge ClK);
      rsp_ready = 1'b0;
      chk("rsp_done", {63'd0, rsp_valid[g]}, 64'd0);
      chk("ready_back", {63'd0, req_ready[g]}, 64'd1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rd;
      logic        rw;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;
         cs_cnt[g] = 0; addr_bad[g] = 1'b0; we_seen[g] = 1'b0;
         bus_seen[g] = '0; first_addr[g] = '0;
         for (int i = 0; i < 128; i++) exp_mem[g][i] = '0;
      end
      repeat (3) @(posedge ClK);
      @(negedge ClK);
      RST = 1'b0;
      // reset state
      chk("rst_req_ready", {63'd0, req_ready[0]}, 64'd1);
      chk("rst_rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
      chk("rst_rsp_rdata", {32'd0, rsp_rdata[0]}, 64'd0);
      chk("rst_rsp_err", {63'd0, rsp_err[0]}, 64'd0);
      chk("rst_cs_we", {62'd0, cs[0], we[0]}, 64'd0);
      chk("rst_addr", {32'd0, addr_o[0]}, 64'd0);

      // store, load back, misaligned and out-of-range
      req(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
      req(0, 1'b0, 32'h10, 32'h0, 0);
      req(0, 1'b0, 32'h13, 32'h0, 0);
      req(0, 1'b0, 32'h200, 32'h0, 0);
      // last valid word, and an errored store that must not touch memory
      req(0, 1'b1, 32'h1FC, 32'hA5A55A5A, 0);
      req(0, 1'b0, 32'h1FC, 32'h0, 0);
      req(0, 1'b1, 32'h12, 32'h11111111, 0);
      // held response with a new request pending
      req(0, 1'b0, 32'h10, 32'h0, 3);
      // mixed traffic over a small window
      for (int i = 0; i < 10; i++) begin
         rw = 1'($urandom_range(0, 1));
         ra = 32'($urandom_range(0, 15)) << 2;
         rd = $urandom;
         req(0, rw, ra, rd, 0);
      end

      // wait-state instance
      req(1, 1'b1, 32'h20, 32'h12345678, 0);
      req(1, 1'b0, 32'h20, 32'h0, 0);
      req(1, 1'b0, 32'h201, 32'h0, 0);

      // reset in the middle of a wait-state store
      @(negedge ClK);
      req_valid[1] = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      @(posedge ClK);
      @(negedge ClK);
      req_valid[1] = 1'b0;
      chk("mid_cs", {63'd0, cs[1]}, 64'd1);
      RST = 1'b1;
      @(posedge ClK);
      @(negedge ClK);
      RST = 1'b0;
      chk("rst_mid_cs_we", {62'd0, cs[1], we[1]}, 64'd0);
      chk("rst_mid_rsp_valid", {63'd0, rsp_valid[1]}, 64'd0);
      chk("rst_mid_req_ready", {63'd0, req_ready[1]}, 64'd1);
      repeat (3) @(posedge ClK);
      @(negedge ClK);
      chk("rst_mid_no_rsp", {63'd0, rsp_valid[1]}, 64'd0);
      chk("rst_mid_cs_idle", {63'd0, cs[1]}, 64'd0);

      // wait-state instance still works after the reset
      req(1, 1'b0, 32'h20, 32'h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
